umi_arbmux: RTL
===============

Name: umi_arbmux

Overview:
- Registered N-to-1 UMI multiplexer with a built-in arbiter. Unlike a one-hot select mux, it accepts any number of simultaneously valid inputs.
- Picks one input per transfer using fixed-priority or round-robin arbitration, selected by parameter.
- Drives a single registered UMI output at full throughput.
- Sits where several UMI request/response sources share one downstream link (crossbar output port, host/device endpoint merge).

Parameters:
- DW, 256, UMI data width
- CW, 32, UMI command width
- AW, 64, UMI address width
- N, 4, number of input channels (1..32)
- ARBMODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin

Ports:
- clk  input  1  clock
- nreset  input  1  synchronous active-low reset; sampled on clk rising edge
- umi_in_valid  input  N  per-input valid
- umi_in_cmd  input  N*CW  packed commands; input i at [i*CW +: CW]
- umi_in_dstaddr  input  N*AW  packed destination addresses
- umi_in_srcaddr  input  N*AW  packed source addresses
- umi_in_data  input  N*DW  packed data
- umi_in_ready  output  N  per-input ready; at most one bit high per cycle
- umi_out_valid  output  1  registered output valid
- umi_out_ready  input  1  downstream ready
- umi_out_cmd  output  CW  registered command
- umi_out_dstaddr  output  AW  registered destination address
- umi_out_srcaddr  output  AW  registered source address
- umi_out_data  output  DW  registered data
- umi_out_sel  output  N  registered one-hot index of the input that sourced the current output word

Behaviour:
- Reset (nreset low at a clk edge):
  - umi_out_valid=0, umi_out_sel=0, all payload registers 0.
  - Round-robin pointer = 0 (input 0 highest priority).
  - While nreset is low, umi_in_ready is forced to all zeros.
- Load enable: load = ~umi_out_valid | umi_out_ready. The output register accepts a new word when it is empty or drains in the same cycle.
- Grant (combinational from umi_in_valid and pointer):
  - gnt is one-hot among the valid inputs.
  - gnt = 0 when no input is valid.
- Ready rule: umi_in_ready[i] = gnt[i] & load & nreset.
  - umi_in_ready may depend on umi_in_valid.
  - No valid output depends combinationally on umi_out_ready.
- Transfer: input i transfers when umi_in_valid[i] & umi_in_ready[i].
  - On that edge, the output registers capture input i's cmd/dstaddr/srcaddr/data.
  - umi_out_sel <= gnt and umi_out_valid <= 1.
- Drain without refill: if umi_out_valid & umi_out_ready and no input is valid, then umi_out_valid <= 0. Payload registers hold their last value.
- Stall: if umi_out_valid & ~umi_out_ready, all output registers hold and umi_in_ready = 0.
- Latency and throughput:
  - Input accept to umi_out_valid: 1 cycle.
  - Sustains one word per cycle when umi_out_ready is held high.
- ARBMODE=0: gnt = lowest-indexed valid input. Starvation of high indices is permitted.
- ARBMODE=1 (round-robin):
  - Search starts at index ptr, wraps modulo N, and grants the first valid input found.
  - ptr updates only on a transfer, to (granted index + 1) mod N; wrap from N-1 goes to 0.
  - ptr holds during stalls and idle cycles, so the grant stays stable while umi_out_ready is low.
- An input that has asserted valid must hold its payload until ready. The block samples payload only on the transfer edge.
- N=1: arbiter degenerates to gnt = umi_in_valid; ptr is constant 0.
- Reset mid-operation: any word held in the output register is dropped (umi_out_valid=0 on the next cycle). No input transfer occurs in a reset cycle.
- Error checking: none; the block never generates or inspects UMI responses. The cmd field passes through unchanged.

Test Plan:
- Reset: hold nreset=0 for 3 cycles with all inputs valid -> umi_in_ready=0, umi_out_valid=0, umi_out_sel=0. First cycle after release, round-robin grants input 0.
- Round-robin fairness, N=4, ARBMODE=1, all 4 inputs always valid with distinct data 0xA0..0xA3, umi_out_ready=1 -> umi_out_data sequence A0,A1,A2,A3,A0,…, one word per cycle, umi_out_sel 0001,0010,0100,1000 repeating.
- Fixed priority, ARBMODE=0, inputs 1 and 3 valid, ready=1 for 5 cycles -> input 1 granted every cycle; umi_in_ready[3]=0 throughout.
- Backpressure: output holds word from input 2, umi_out_ready=0 for 4 cycles while inputs 0 and 2 are valid -> output registers and ptr unchanged, umi_in_ready=0. When ready rises, the next grant is input 0 (ptr=3 wraps).
- Sparse and idle traffic: single valid pulse on input 3, then none -> umi_out_valid high for exactly 1 cycle (ready=1) at cycle+1, then low. ptr becomes 0.
- Reset mid-stall: umi_out_valid=1, umi_out_ready=0, assert nreset=0 for one cycle -> umi_out_valid=0 next cycle, word dropped, ptr=0.

Source files
------------

// File: rtl/umi_arbmux.sv
// Registered N-to-1 UMI multiplexer with built-in fixed-priority or round-robin
// arbiter; one word per cycle when the downstream link keeps ready high.
module umi_arbmux #(
  parameter int unsigned DW      = 256,
  parameter int unsigned CW      = 32,
  parameter int unsigned AW      = 64,
  parameter int unsigned N       = 4,
  parameter int unsigned ARBMODE = 1
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic [N-1:0]    umi_in_valid,
  input  logic [N*CW-1:0] umi_in_cmd,
  input  logic [N*AW-1:0] umi_in_dstaddr,
  input  logic [N*AW-1:0] umi_in_srcaddr,
  input  logic [N*DW-1:0] umi_in_data,
  output logic [N-1:0]    umi_in_ready,
  output logic            umi_out_valid,
  input  logic            umi_out_ready,
  output logic [CW-1:0]   umi_out_cmd,
  output logic [AW-1:0]   umi_out_dstaddr,
  output logic [AW-1:0]   umi_out_srcaddr,
  output logic [DW-1:0]   umi_out_data,
  output logic [N-1:0]    umi_out_sel
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   base;
  logic [2*N-1:0]  rot;
  logic [PW-1:0]   first;
  logic [PW:0]     sum;
  logic [PW-1:0]   gnt_idx;
  logic            found;
  logic [N-1:0]    gnt;
  logic            load;

  logic            valid_q;
  logic [N-1:0]    sel_q;
  logic [CW-1:0]   cmd_q, cmd_d;
  logic [AW-1:0]   dst_q, dst_d;
  logic [AW-1:0]   src_q, src_d;
  logic [DW-1:0]   data_q, data_d;

  assign load         = ~valid_q | umi_out_ready;
  assign umi_in_ready = gnt & {N{load & nreset}};

  // Rotate the valid vector so the search always starts at bit 0, then map the
  // first hit back to an absolute index with a single modulo-N correction.
  always_comb begin
    base    = (ARBMODE == 0) ? '0 : ptr_q;
    rot     = {umi_in_valid, umi_in_valid} >> base;
    found   = 1'b0;
    first   = '0;
    for (int unsigned j = 0; j < N; j++) begin
      if (!found && rot[j]) begin
        found = 1'b1;
        first = PW'(j);
      end
    end
    sum     = {1'b0, base} + {1'b0, first};
    gnt_idx = (sum >= (PW+1)'(N)) ? PW'(sum - (PW+1)'(N)) : PW'(sum);
    gnt     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      gnt[i] = found && (gnt_idx == PW'(i));
    end
    ptr_d   = (gnt_idx == PW'(N-1)) ? '0 : gnt_idx + PW'(1);
  end

  always_comb begin
    cmd_d  = '0;
    dst_d  = '0;
    src_d  = '0;
    data_d = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (gnt[i]) begin
        cmd_d  = umi_in_cmd[i*CW +: CW];
        dst_d  = umi_in_dstaddr[i*AW +: AW];
        src_d  = umi_in_srcaddr[i*AW +: AW];
        data_d = umi_in_data[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      valid_q <= 1'b0;
      sel_q   <= '0;
      cmd_q   <= '0;
      dst_q   <= '0;
      src_q   <= '0;
      data_q  <= '0;
      ptr_q   <= '0;
    end else if (load) begin
      if (found) begin
        valid_q <= 1'b1;
        sel_q   <= gnt;
        cmd_q   <= cmd_d;
        dst_q   <= dst_d;
        src_q   <= src_d;
        data_q  <= data_d;
        if (ARBMODE != 0) begin
          ptr_q <= ptr_d;
        end
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  assign umi_out_valid   = valid_q;
  assign umi_out_sel     = sel_q;
  assign umi_out_cmd     = cmd_q;
  assign umi_out_dstaddr = dst_q;
  assign umi_out_srcaddr = src_q;
  assign umi_out_data    = data_q;

endmodule
